// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with status flags, sticky error flags, synchronous
// clear, replace-top (push+pop) and a one-cycle read strobe.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   clear             synchronous flush of contents and error flags
//   push, pop, peek   stack operations (peek ignored when push or pop is set)
//   din               push data
//   dout              registered read data, held between reads
//   dout_valid        dout was updated by the most recent edge
//   count             number of valid entries, 0..DEPTH
//   empty, full       count == 0 / count == DEPTH
//   almost_full       count >= AFULL_LEVEL
//   overflow          sticky: push refused on a full stack
//   underflow         sticky: pop or peek on an empty stack
module lifo_stack #(
  parameter int WIDTH       = 135,
  parameter int DEPTH       = 128,
  parameter int AFULL_LEVEL = DEPTH - 4,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             peek,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Threshold clamped into 0..DEPTH+1 so the compare needs one extra bit only.
  localparam int unsigned AF_U = (AFULL_LEVEL <= 0) ? 0 :
                                 (AFULL_LEVEL > DEPTH) ? DEPTH + 1 : AFULL_LEVEL;

  logic [WIDTH-1:0] mem [DEPTH];

  logic          has_data;
  logic          not_full;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          rd_en;
  logic [CW-1:0] count_nxt;
  logic          ovf_set;
  logic          udf_set;

  assign has_data    = (count != '0);
  assign not_full    = (count < CW'(DEPTH));
  assign top_idx     = AW'(count - CW'(1));
  assign empty       = ~has_data;
  assign full        = (count == CW'(DEPTH));
  assign almost_full = ({1'b0, count} >= (CW + 1)'(AF_U));

  // Operation decode, one action per edge in priority order.
  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = top_idx;
    rd_en     = 1'b0;
    count_nxt = count;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (push && pop) begin
      wr_en = 1'b1;
      if (has_data) begin
        rd_en = 1'b1;
      end else begin
        wr_addr   = '0;
        count_nxt = CW'(1);
        udf_set   = 1'b1;
      end
    end else if (pop) begin
      if (has_data) begin
        rd_en     = 1'b1;
        count_nxt = count - CW'(1);
      end else begin
        udf_set = 1'b1;
      end
    end else if (push) begin
      if (not_full) begin
        wr_en     = 1'b1;
        wr_addr   = AW'(count);
        count_nxt = count + CW'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (peek) begin
      if (has_data) rd_en = 1'b1;
      else          udf_set = 1'b1;
    end
  end

  // Storage array is not reset; old top is read before a replace-top write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  // Control and read registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      count      <= count_nxt;
      dout_valid <= rd_en;
      if (rd_en) dout <= mem[top_idx];
      if (clear) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        overflow  <= overflow | ovf_set;
        underflow <= underflow | udf_set;
      end
    end
  end

endmodule
